// File: rtl/pcpi_simd_pkg.sv
// Shared definitions for the PCPI packed-SIMD co-processor:
// opcode default, funct7 op codes, FSM states and lane count.
package pcpi_simd_pkg;

    localparam logic [6:0] CUSTOM_OPCODE_DEF = 7'b0001011;
    localparam int LANES = 4;

    typedef enum logic [2:0] {
        OP_VADD8   = 3'd0,
        OP_VSUB8   = 3'd1,
        OP_VMAXU8  = 3'd2,
        OP_VMINU8  = 3'd3,
        OP_VSAD8   = 3'd4,
        OP_VDOT8S  = 3'd5,
        OP_VDOTA   = 3'd6,
        OP_VACCCLR = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    // Ops that reduce across lanes and may run one lane per cycle
    function automatic logic is_reduce(input op_e op);
        return (op == OP_VSAD8) || (op == OP_VDOT8S) || (op == OP_VDOTA);
    endfunction

endpackage

// File: rtl/pcpi_simd_unit_if.sv
// PCPI handshake bundle between the core (master) and the
// SIMD co-processor (slave).
interface pcpi_simd_unit_if;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );
endinterface

// File: rtl/pcpi_simd_lane_alu.sv
// One byte lane: wrap add/sub, unsigned |diff|, min/max and
// signed 8x8 product.
module pcpi_simd_lane_alu (
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [7:0]  o_sum,
    output logic [7:0]  o_diff,
    output logic [7:0]  o_absd,
    output logic [7:0]  o_min,
    output logic [7:0]  o_max,
    output logic [15:0] o_prod
);
    logic        w_ge;
    logic [15:0] w_sa;
    logic [15:0] w_sb;

    assign w_ge   = (i_a >= i_b);
    assign w_sa   = {{8{i_a[7]}}, i_a};
    assign w_sb   = {{8{i_b[7]}}, i_b};
    assign o_sum  = i_a + i_b;
    assign o_diff = i_a - i_b;
    assign o_absd = w_ge ? (i_a - i_b) : (i_b - i_a);
    assign o_min  = w_ge ? i_b : i_a;
    assign o_max  = w_ge ? i_a : i_b;
    // Low 16 bits of the sign-extended product equal the signed product
    assign o_prod = w_sa * w_sb;
endmodule

// File: rtl/pcpi_simd_unit.sv
// PCPI responder claiming custom-0 instructions and returning
// packed 4x8-bit SIMD results, with an optional dot accumulator.
module pcpi_simd_unit
    import pcpi_simd_pkg::*;
#(
    parameter logic [6:0] CUSTOM_OPCODE = CUSTOM_OPCODE_DEF,
    parameter int         LANE_SERIAL   = 1,
    parameter int         ENABLE_ACC    = 1
) (
    input  logic             clk,
    input  logic             resetn,
    pcpi_simd_unit_if.slave  bus,
    output logic             busy
);
    state_e      r_state;
    op_e         r_op;
    logic [1:0]  r_cnt;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [31:0] r_part;
    logic [31:0] r_acc;
    logic [31:0] r_rd;
    logic        r_wait;
    logic        r_ready;
    logic        r_wr;

    logic [6:0]  w_f7;
    logic        w_match;
    logic        w_last;
    logic [31:0] w_add;
    logic [31:0] w_sub;
    logic [31:0] w_min;
    logic [31:0] w_max;
    logic [7:0]  w_absd [LANES];
    logic [15:0] w_prod [LANES];
    logic [31:0] w_sad_all;
    logic [31:0] w_dot_all;
    logic [31:0] w_term;
    logic [31:0] w_ser_sum;
    logic [31:0] w_sad;
    logic [31:0] w_dot;
    logic [31:0] w_res;
    logic [31:0] w_acc_nx;

    assign w_f7    = bus.pcpi_insn[31:25];
    assign w_match = (bus.pcpi_insn[6:0] == CUSTOM_OPCODE)
                  && (bus.pcpi_insn[14:12] == 3'b000)
                  && (w_f7[6:3] == 4'd0)
                  && ((ENABLE_ACC != 0) || (w_f7[2:1] != 2'b11));

    genvar g;
    for (g = 0; g < LANES; g++) begin : g_lane
        pcpi_simd_lane_alu u_alu (
            .i_a    (r_rs1[8*g +: 8]),
            .i_b    (r_rs2[8*g +: 8]),
            .o_sum  (w_add[8*g +: 8]),
            .o_diff (w_sub[8*g +: 8]),
            .o_absd (w_absd[g]),
            .o_min  (w_min[8*g +: 8]),
            .o_max  (w_max[8*g +: 8]),
            .o_prod (w_prod[g])
        );
    end

    // Cross-lane reductions: full adder tree or one lane per cycle
    always_comb begin
        w_sad_all = '0;
        w_dot_all = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sad_all = w_sad_all + {24'd0, w_absd[i]};
            w_dot_all = w_dot_all
                      + {{16{w_prod[i][15]}}, w_prod[i]};
        end
        if (r_op == OP_VSAD8) begin
            w_term = {24'd0, w_absd[r_cnt]};
        end else begin
            w_term = {{16{w_prod[r_cnt][15]}}, w_prod[r_cnt]};
        end
        w_ser_sum = r_part + w_term;
        w_sad = (LANE_SERIAL != 0) ? w_ser_sum : w_sad_all;
        w_dot = (LANE_SERIAL != 0) ? w_ser_sum : w_dot_all;
    end

    assign w_last = (LANE_SERIAL == 0) || !is_reduce(r_op)
                 || (r_cnt == 2'(LANES - 1));

    // Final result and next accumulator value for the latched op
    always_comb begin
        w_res    = '0;
        w_acc_nx = r_acc;
        unique case (r_op)
            OP_VADD8:   w_res = w_add;
            OP_VSUB8:   w_res = w_sub;
            OP_VMAXU8:  w_res = w_max;
            OP_VMINU8:  w_res = w_min;
            OP_VSAD8:   w_res = w_sad;
            OP_VDOT8S:  w_res = w_dot;
            OP_VDOTA: begin
                w_res    = r_acc + w_dot;
                w_acc_nx = r_acc + w_dot;
            end
            OP_VACCCLR: begin
                w_res    = r_acc;
                w_acc_nx = '0;
            end
        endcase
    end

    // Handshake FSM with registered PCPI outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_op    <= OP_VADD8;
            r_cnt   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_part  <= '0;
            r_acc   <= '0;
            r_rd    <= '0;
            r_wait  <= 1'b0;
            r_ready <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_wr    <= 1'b0;
            r_rd    <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.pcpi_valid && w_match) begin
                        r_rs1   <= bus.pcpi_rs1;
                        r_rs2   <= bus.pcpi_rs2;
                        r_op    <= op_e'(w_f7[2:0]);
                        r_cnt   <= '0;
                        r_part  <= '0;
                        r_wait  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!bus.pcpi_valid) begin
                        r_wait  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (!w_last) begin
                        r_part <= w_ser_sum;
                        r_cnt  <= r_cnt + 2'd1;
                    end else begin
                        r_ready <= 1'b1;
                        r_wr    <= 1'b1;
                        r_rd    <= w_res;
                        r_wait  <= 1'b0;
                        r_acc   <= w_acc_nx;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: r_state <= S_HOLD;
                S_HOLD: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.pcpi_wait  = r_wait;
    assign bus.pcpi_ready = r_ready;
    assign bus.pcpi_wr    = r_wr;
    assign bus.pcpi_rd    = r_rd;
    assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_pcpi_simd_unit.sv
// Scoreboard bench: serial and parallel instances driven in turn,
// responses popped and compared by independent monitors.
module tb_pcpi_simd_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        v_s = 1'b0;
    logic        v_p = 1'b0;
    logic [31:0] insn = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        busy_s;
    logic        busy_p;

    always #5 clk = ~clk;

    pcpi_simd_unit_if ifs ();
    pcpi_simd_unit_if ifp ();

    assign ifs.pcpi_valid = v_s;
    assign ifs.pcpi_insn  = insn;
    assign ifs.pcpi_rs1   = rs1;
    assign ifs.pcpi_rs2   = rs2;
    assign ifp.pcpi_valid = v_p;
    assign ifp.pcpi_insn  = insn;
    assign ifp.pcpi_rs1   = rs1;
    assign ifp.pcpi_rs2   = rs2;

    pcpi_simd_unit #(.LANE_SERIAL(1)) dut_s (
        .clk(clk), .resetn(resetn), .bus(ifs.slave), .busy(busy_s)
    );
    pcpi_simd_unit #(.LANE_SERIAL(0)) dut_p (
        .clk(clk), .resetn(resetn), .bus(ifp.slave), .busy(busy_p)
    );

    typedef struct {
        logic [31:0] rd;
        int          at;
    } exp_t;

    exp_t q_s[$];
    exp_t q_p[$];
    exp_t e_s;
    exp_t e_p;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;
    int   tgt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_resp(input string nm, input logic has,
                              input exp_t e, input logic [31:0] rd,
                              input logic wr);
        checks++;
        if (!has) begin
            errs++;
            $display("FAIL %s unexpected ready rd=%h cyc=%0d",
                     nm, rd, cyc);
        end else if (rd !== e.rd || wr !== 1'b1 || cyc != e.at) begin
            errs++;
            $display("FAIL %s resp got rd=%h wr=%b cyc=%0d want rd=%h wr=1 cyc=%0d",
                     nm, rd, wr, cyc, e.rd, e.at);
        end
    endtask

    always @(negedge clk) begin
        if (ifs.pcpi_ready === 1'b1) begin
            e_s = '{32'd0, 0};
            if (q_s.size() > 0) begin
                e_s = q_s.pop_front();
                check_resp("ser", 1'b1, e_s, ifs.pcpi_rd, ifs.pcpi_wr);
            end else begin
                check_resp("ser", 1'b0, e_s, ifs.pcpi_rd, ifs.pcpi_wr);
            end
        end
    end

    always @(negedge clk) begin
        if (ifp.pcpi_ready === 1'b1) begin
            e_p = '{32'd0, 0};
            if (q_p.size() > 0) begin
                e_p = q_p.pop_front();
                check_resp("par", 1'b1, e_p, ifp.pcpi_rd, ifp.pcpi_wr);
            end else begin
                check_resp("par", 1'b0, e_p, ifp.pcpi_rd, ifp.pcpi_wr);
            end
        end
    end

    function automatic logic [31:0] mk(input logic [6:0] f7,
                                       input logic [2:0] f3,
                                       input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    function automatic logic t_ready();
        return (tgt == 1) ? ifs.pcpi_ready : ifp.pcpi_ready;
    endfunction

    function automatic logic t_wait();
        return (tgt == 1) ? ifs.pcpi_wait : ifp.pcpi_wait;
    endfunction

    function automatic logic t_wr();
        return (tgt == 1) ? ifs.pcpi_wr : ifp.pcpi_wr;
    endfunction

    task automatic drive_valid(input logic x);
        v_s = (tgt == 1) ? x : 1'b0;
        v_p = (tgt == 0) ? x : 1'b0;
    endtask

    task automatic run_op(input logic [6:0] f7, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_rd);
        int   lat;
        int   wt;
        logic got;
        exp_t e;
        lat = (tgt == 1 && f7 >= 7'd4 && f7 <= 7'd6) ? 5 : 2;
        @(negedge clk);
        insn = mk(f7, 3'b000, 7'h0B);
        rs1  = a;
        rs2  = b;
        drive_valid(1'b1);
        e.rd = exp_rd;
        e.at = cyc + lat;
        if (tgt == 1) q_s.push_back(e);
        else q_p.push_back(e);
        wt  = 0;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            rs1 = $urandom;
            rs2 = $urandom;
            if (t_ready()) got = 1'b1;
            else if (t_wait()) wt++;
        end
        checks++;
        if (!got) begin
            errs++;
            $display("FAIL timeout f7=%0d tgt=%0d no ready", f7, tgt);
        end else if (wt != lat - 1) begin
            errs++;
            $display("FAIL wait_len f7=%0d tgt=%0d got %0d want %0d",
                     f7, tgt, wt, lat - 1);
        end
        @(negedge clk);
        drive_valid(1'b0);
    endtask

    task automatic run_bad(input string nm, input logic [31:0] w);
        logic bad;
        @(negedge clk);
        insn = w;
        rs1  = 32'h01010101;
        rs2  = 32'h01010101;
        drive_valid(1'b1);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (t_wait() || t_ready() || t_wr()) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errs++;
            $display("FAIL %s claimed got wait/ready/wr activity want none",
                     nm);
        end
        drive_valid(1'b0);
        @(negedge clk);
    endtask

    task automatic run_abort(input logic [6:0] f7);
        logic bad;
        @(negedge clk);
        insn = mk(f7, 3'b000, 7'h0B);
        rs1  = 32'h01010101;
        rs2  = 32'h02020202;
        drive_valid(1'b1);
        @(negedge clk);
        drive_valid(1'b0);
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (t_wait() || t_ready()) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errs++;
            $display("FAIL abort tgt=%0d got wait/ready after drop want 0",
                     tgt);
        end
    endtask

    task automatic run_reset();
        @(negedge clk);
        insn = mk(7'd6, 3'b000, 7'h0B);
        rs1  = 32'h01010101;
        rs2  = 32'h02020202;
        drive_valid(1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy_s !== 1'b1 || ifs.pcpi_wait !== 1'b1) begin
            errs++;
            $display("FAIL pre_reset got busy=%b wait=%b want 1 1",
                     busy_s, ifs.pcpi_wait);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (ifs.pcpi_wait !== 1'b0 || ifs.pcpi_ready !== 1'b0 ||
            ifs.pcpi_wr !== 1'b0 || ifs.pcpi_rd !== 32'd0 ||
            busy_s !== 1'b0) begin
            errs++;
            $display("FAIL mid_reset got wait=%b ready=%b wr=%b rd=%h busy=%b want 0",
                     ifs.pcpi_wait, ifs.pcpi_ready, ifs.pcpi_wr,
                     ifs.pcpi_rd, busy_s);
        end
        drive_valid(1'b0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        checks++;
        if (ifs.pcpi_wait !== 1'b0 || ifs.pcpi_ready !== 1'b0 ||
            ifs.pcpi_wr !== 1'b0 || ifs.pcpi_rd !== 32'd0 ||
            ifp.pcpi_wait !== 1'b0 || ifp.pcpi_ready !== 1'b0 ||
            ifp.pcpi_wr !== 1'b0 || ifp.pcpi_rd !== 32'd0 ||
            busy_s !== 1'b0 || busy_p !== 1'b0) begin
            errs++;
            $display("FAIL reset_state outputs not all zero");
        end
        resetn = 1'b1;

        for (int t = 0; t < 2; t++) begin
            tgt = t;
            run_op(7'd0, 32'h01FF7F80, 32'h01010101, 32'h02008081);
            run_op(7'd1, 32'h10000305, 32'h01010102, 32'h0FFF0203);
            run_op(7'd2, 32'h80017FFF, 32'h7F0280FE, 32'h800280FF);
            run_op(7'd3, 32'h80017FFF, 32'h7F0280FE, 32'h7F017FFE);
            run_op(7'd4, 32'h00FF1020, 32'hFF001030, 32'h0000020E);
            run_op(7'd5, 32'h80FF0102, 32'h7F020304, 32'hFFFFC089);
            run_op(7'd6, 32'h01010101, 32'h02020202, 32'd8);
            run_op(7'd6, 32'h01010101, 32'h02020202, 32'd16);
            run_op(7'd7, 32'h0, 32'h0, 32'd16);
            run_op(7'd6, 32'h01010101, 32'h02020202, 32'd8);
            run_op(7'd7, 32'h0, 32'h0, 32'd8);
            run_bad("f7_7f", mk(7'h7F, 3'b000, 7'h0B));
            run_bad("f3_1", mk(7'd0, 3'b001, 7'h0B));
            run_bad("opc_33", mk(7'd0, 3'b000, 7'h33));
            run_op(7'd6, 32'h01010101, 32'h02020202, 32'd8);
            run_abort(7'd6);
            run_op(7'd7, 32'h0, 32'h0, 32'd8);
            run_op(7'd0, 32'h01FF7F80, 32'h01010101, 32'h02008081);
        end

        tgt = 1;
        run_op(7'd6, 32'h01010101, 32'h02020202, 32'd8);
        run_reset();
        run_op(7'd7, 32'h0, 32'h0, 32'd0);
        run_op(7'd0, 32'h01FF7F80, 32'h01010101, 32'h02008081);

        repeat (5) @(negedge clk);
        checks++;
        if (q_s.size() != 0 || q_p.size() != 0) begin
            errs++;
            $display("FAIL pending got %0d/%0d queued want 0",
                     q_s.size(), q_p.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
